// File: rtl/risc5_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state type and the iteration counter sizing helper.
package risc5_muldiv_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must reach WIDTH-1, one count per radix-2 step.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling around the unsigned iterative core: operand
// magnitude extraction on the way in, product/quotient/remainder sign fix on the way out.
module muldiv_signfix
  import risc5_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             x_neg_o,
  output logic             y_neg_o,
  output logic [WIDTH-1:0] x_abs_o,
  output logic [WIDTH-1:0] y_abs_o,
  input  logic             op_i,
  input  logic             x_neg_i,
  input  logic             y_neg_i,
  input  logic [WIDTH-1:0] lo_mag_i,
  input  logic [WIDTH-1:0] hi_mag_i,
  input  logic [WIDTH-1:0] y_abs_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod_s;
  logic               res_neg;
  logic               rem_fix;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   rem_val;

  // MIN maps to 2^(WIDTH-1), which is still representable as an unsigned magnitude.
  assign x_neg_o = sgn_i & x_i[WIDTH-1];
  assign y_neg_o = sgn_i & y_i[WIDTH-1];
  assign x_abs_o = x_neg_o ? -x_i : x_i;
  assign y_abs_o = y_neg_o ? -y_i : y_i;

  assign res_neg = x_neg_i ^ y_neg_i;

  always_comb begin
    prod_u  = {hi_mag_i, lo_mag_i};
    prod_s  = res_neg ? -prod_u : prod_u;
    // Euclidean: a negative dividend with nonzero remainder pulls the quotient
    // one step further from zero and folds the remainder into [0, |y|).
    rem_fix = x_neg_i & (|hi_mag_i);
    quo_mag = lo_mag_i + {{(WIDTH-1){1'b0}}, rem_fix};
    rem_val = rem_fix ? (y_abs_i - hi_mag_i) : hi_mag_i;
    lo_o    = prod_s[WIDTH-1:0];
    hi_o    = prod_s[2*WIDTH-1:WIDTH];
    if (op_i == OP_DIV) begin
      lo_o = res_neg ? -quo_mag : quo_mag;
      hi_o = rem_val;
    end
  end

endmodule

// File: rtl/risc5_muldiv.sv
// Iterative radix-2 multiplier / Euclidean divider, one step per ce cycle;
// stall is high from run until DONE (WIDTH+1 ce cycles, 1 for fast divide-by-zero).
module risc5_muldiv
  import risc5_muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FAST_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             run,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             stall,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   sh_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   x_q;
  logic               op_q;
  logic               xn_q;
  logic               yn_q;
  logic               yz_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic               dz_q;

  logic               x_neg;
  logic               y_neg;
  logic [WIDTH-1:0]   x_abs;
  logic [WIDTH-1:0]   y_abs;
  logic               y_zero;
  logic               fast_dz;
  logic [WIDTH+1:0]   add_a;
  logic [WIDTH+1:0]   add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   sum_d;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   sh_d;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH-1:0]   fix_hi;

  assign stall   = run & (state_q != ST_DONE);
  assign lo      = lo_q;
  assign hi      = hi_q;
  assign dz      = dz_q;
  assign y_zero  = (y == '0);
  assign fast_dz = (FAST_ZERO != 0) && (op == OP_DIV) && y_zero;

  muldiv_signfix #(
    .WIDTH (WIDTH)
  ) u_signfix (
    .sgn_i    (sgn),
    .x_i      (x),
    .y_i      (y),
    .x_neg_o  (x_neg),
    .y_neg_o  (y_neg),
    .x_abs_o  (x_abs),
    .y_abs_o  (y_abs),
    .op_i     (op_q),
    .x_neg_i  (xn_q),
    .y_neg_i  (yn_q),
    .lo_mag_i (sh_d),
    .hi_mag_i (acc_d),
    .y_abs_i  (m_q),
    .lo_o     (fix_lo),
    .hi_o     (fix_hi)
  );

  // Single adder: MUL adds the multiplicand when the multiplier LSB is set,
  // DIV subtracts the divisor from the shifted partial remainder.
  always_comb begin
    add_a   = {2'b00, acc_q};
    add_b   = sh_q[0] ? {2'b00, m_q} : '0;
    add_cin = 1'b0;
    if (op_q == OP_DIV) begin
      add_a   = {1'b0, acc_q, sh_q[WIDTH-1]};
      add_b   = {2'b11, ~m_q};
      add_cin = 1'b1;
    end
    sum_d = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};
  end

  always_comb begin
    acc_d = sum_d[WIDTH:1];
    sh_d  = {sum_d[0], sh_q[WIDTH-1:1]};
    if (op_q == OP_DIV) begin
      if (!sum_d[WIDTH+1]) begin
        acc_d = sum_d[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      m_q     <= '0;
      x_q     <= '0;
      op_q    <= OP_MUL;
      xn_q    <= 1'b0;
      yn_q    <= 1'b0;
      yz_q    <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
    end else if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            x_q   <= x;
            op_q  <= op;
            xn_q  <= x_neg;
            yn_q  <= y_neg;
            yz_q  <= y_zero;
            sh_q  <= x_abs;
            m_q   <= y_abs;
            acc_q <= '0;
            cnt_q <= '0;
            if (fast_dz) begin
              state_q <= ST_DONE;
              lo_q    <= '1;
              hi_q    <= x;
              dz_q    <= 1'b1;
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (!run) begin
            state_q <= ST_IDLE;
          end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_DONE;
              if ((op_q == OP_DIV) && yz_q) begin
                lo_q <= '1;
                hi_q <= x_q;
                dz_q <= 1'b1;
              end else begin
                lo_q <= fix_lo;
                hi_q <= fix_hi;
                dz_q <= 1'b0;
              end
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_risc5_muldiv.sv
// Scoreboard bench for risc5_muldiv: two instances (FAST_ZERO=1 and 0) share operands.
module tb_risc5_muldiv;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, ce, run0, run1, op, sgn;
  logic [W-1:0] x, y;
  logic         stall0, stall1, dz0, dz1;
  logic [W-1:0] lo0, hi0, lo1, hi1;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t last_e;

  always #5 clk = ~clk;

  risc5_muldiv #(.WIDTH(W), .FAST_ZERO(1)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .run(run0), .op(op), .sgn(sgn), .x(x), .y(y),
    .stall(stall0), .lo(lo0), .hi(hi0), .dz(dz0));

  risc5_muldiv #(.WIDTH(W), .FAST_ZERO(0)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .run(run1), .op(op), .sgn(sgn), .x(x), .y(y),
    .stall(stall1), .lo(lo1), .hi(hi1), .dz(dz1));

  function automatic exp_t mk(input logic [W-1:0] l, input logic [W-1:0] h, input logic d);
    exp_t e;
    e.lo = l; e.hi = h; e.dz = d;
    return e;
  endfunction

  // Reference built on native 64-bit arithmetic.
  function automatic exp_t model(input bit op_v, input bit sgn_v, input logic [W-1:0] xv, input logic [W-1:0] yv);
    exp_t        e;
    logic [63:0] pu;
    longint      xs, ys, p, q, r;
    e.dz = 1'b0;
    if (!op_v) begin
      if (sgn_v) begin
        xs = longint'($signed(xv)); ys = longint'($signed(yv)); p = xs * ys;
        e.lo = p[31:0]; e.hi = p[63:32];
      end else begin
        pu = {32'b0, xv} * {32'b0, yv};
        e.lo = pu[31:0]; e.hi = pu[63:32];
      end
    end else if (yv == '0) begin
      e.lo = '1; e.hi = xv; e.dz = 1'b1;
    end else if (!sgn_v) begin
      e.lo = xv / yv; e.hi = xv % yv;
    end else begin
      xs = longint'($signed(xv)); ys = longint'($signed(yv));
      q = xs / ys; r = xs % ys;
      if (r < 0) begin
        if (ys > 0) begin q = q - 1; r = r + ys; end
        else begin q = q + 1; r = r - ys; end
      end
      e.lo = q[31:0]; e.hi = r[31:0];
    end
    return e;
  endfunction

  task automatic do_op(input string name, input bit en0, input bit en1, input bit op_v, input bit sgn_v,
                       input logic [W-1:0] xv, input logic [W-1:0] yv, input bit toggle,
                       input int exp_c0, input int exp_c1);
    exp_t e, r0, r1;
    int   c0 = 0, c1 = 0, guard = 0;
    bit   done0, done1;
    r0 = '0; r1 = '0;
    @(negedge clk);
    op = op_v; sgn = sgn_v; x = xv; y = yv; ce = 1'b1;
    run0 = en0; run1 = en1;
    done0 = !en0; done1 = !en1;
    while (!(done0 && done1) && guard < 300) begin
      #1;
      if (!done0) begin
        if (stall0) begin if (ce) c0++; end
        else begin r0 = mk(lo0, hi0, dz0); run0 = 1'b0; done0 = 1'b1; end
      end
      if (!done1) begin
        if (stall1) begin if (ce) c1++; end
        else begin r1 = mk(lo1, hi1, dz1); run1 = 1'b0; done1 = 1'b1; end
      end
      @(negedge clk);
      guard++;
      op = 1'($urandom); sgn = 1'($urandom); x = $urandom; y = $urandom;
      if (toggle) ce = ~ce;
    end
    checks++;
    if (guard >= 300) begin
      failures++;
      $display("FAIL %s timeout: done0=%0b done1=%0b, required both done", name, done0, done1);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      last_e = e;
      if (en0) begin
        checks++; if (r0.lo !== e.lo) begin failures++; $display("FAIL %s fz1 lo got=%h exp=%h", name, r0.lo, e.lo); end
        checks++; if (r0.hi !== e.hi) begin failures++; $display("FAIL %s fz1 hi got=%h exp=%h", name, r0.hi, e.hi); end
        checks++; if (r0.dz !== e.dz) begin failures++; $display("FAIL %s fz1 dz got=%b exp=%b", name, r0.dz, e.dz); end
        checks++; if (c0 != exp_c0) begin failures++; $display("FAIL %s fz1 stall cycles got=%0d exp=%0d", name, c0, exp_c0); end
      end
      if (en1) begin
        checks++; if (r1.lo !== e.lo) begin failures++; $display("FAIL %s fz0 lo got=%h exp=%h", name, r1.lo, e.lo); end
        checks++; if (r1.hi !== e.hi) begin failures++; $display("FAIL %s fz0 hi got=%h exp=%h", name, r1.hi, e.hi); end
        checks++; if (r1.dz !== e.dz) begin failures++; $display("FAIL %s fz0 dz got=%b exp=%b", name, r1.dz, e.dz); end
        checks++; if (c1 != exp_c1) begin failures++; $display("FAIL %s fz0 stall cycles got=%0d exp=%0d", name, c1, exp_c1); end
      end
    end
    ce = 1'b1; run0 = 1'b0; run1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (lo0 !== '0 || hi0 !== '0) begin failures++; $display("FAIL reset lo/hi got=%h/%h exp=0/0", lo0, hi0); end
    checks++; if (dz0 !== 1'b0 || dz1 !== 1'b0) begin failures++; $display("FAIL reset dz got=%b/%b exp=0", dz0, dz1); end
    checks++; if (stall0 !== 1'b0 || stall1 !== 1'b0) begin failures++; $display("FAIL reset stall got=%b/%b exp=0", stall0, stall1); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mul;
    sb.push_back(mk(32'h0000_0001, 32'hFFFF_FFFE, 1'b0));
    do_op("mul_uff", 1, 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33, 33);
    sb.push_back(mk(32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0));
    do_op("mul_s_ce", 1, 1, 1'b0, 1'b1, -32'sd3, 32'sd5, 1, 33, 33);
  endtask

  task automatic test_sdiv;
    sb.push_back(mk(-32'sd4, 32'd1, 1'b0));
    do_op("sdiv_m7_2", 1, 1, 1'b1, 1'b1, -32'sd7, 32'sd2, 0, 33, 33);
    sb.push_back(mk(-32'sd3, 32'd1, 1'b0));
    do_op("sdiv_7_m2", 1, 1, 1'b1, 1'b1, 32'sd7, -32'sd2, 0, 33, 33);
    sb.push_back(mk(32'd4, 32'd1, 1'b0));
    do_op("sdiv_m7_m2", 1, 1, 1'b1, 1'b1, -32'sd7, -32'sd2, 0, 33, 33);
    sb.push_back(mk(32'h8000_0000, 32'd0, 1'b0));
    do_op("sdiv_min_m1", 1, 1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33, 33);
  endtask

  task automatic test_div_zero;
    sb.push_back(mk(32'hFFFF_FFFF, 32'd123, 1'b1));
    do_op("div0_fz1", 1, 0, 1'b1, 1'b0, 32'd123, 32'd0, 0, 1, 0);
    sb.push_back(mk(32'hFFFF_FFFF, 32'd123, 1'b1));
    do_op("div0_fz0", 0, 1, 1'b1, 1'b0, 32'd123, 32'd0, 0, 0, 33);
    sb.push_back(mk(32'hFFFF_FFFF, -32'sd5, 1'b1));
    do_op("sdiv0_both", 1, 1, 1'b1, 1'b1, -32'sd5, 32'd0, 0, 1, 33);
  endtask

  task automatic test_random;
    bit           o, s;
    logic [W-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom); s = 1'($urandom); a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if (i % 4 == 0) b = W'($urandom_range(1, 9));
      sb.push_back(model(o, s, a, b));
      do_op("random", 1, 1, o, s, a, b, (i % 5 == 0), (o && b == '0) ? 1 : 33, 33);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   c, guard;
    sb.push_back(model(1'b0, 1'b1, 32'd7, -32'sd9));
    sb.push_back(model(1'b1, 1'b0, 32'd1000, 32'd7));
    @(negedge clk);
    op = 1'b0; sgn = 1'b1; x = 32'd7; y = -32'sd9; ce = 1'b1; run0 = 1'b1; run1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      c = 0; guard = 0;
      #1;
      while (stall0 && guard < 100) begin
        c++; @(negedge clk); #1; guard++;
      end
      e = sb.pop_front();
      last_e = e;
      checks++; if (c != 33) begin failures++; $display("FAIL b2b[%0d] stall cycles got=%0d exp=33", k, c); end
      checks++; if (lo0 !== e.lo || hi0 !== e.hi) begin failures++; $display("FAIL b2b[%0d] lo/hi got=%h/%h exp=%h/%h", k, lo0, hi0, e.lo, e.hi); end
      checks++; if (lo1 !== e.lo || hi1 !== e.hi) begin failures++; $display("FAIL b2b[%0d] fz0 lo/hi got=%h/%h exp=%h/%h", k, lo1, hi1, e.lo, e.hi); end
      if (k == 0) begin
        op = 1'b1; sgn = 1'b0; x = 32'd1000; y = 32'd7;
        @(negedge clk);
      end
    end
    run0 = 1'b0; run1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_abort;
    @(negedge clk);
    op = 1'b0; sgn = 1'b0; x = $urandom; y = $urandom; ce = 1'b1; run0 = 1'b1; run1 = 1'b1;
    repeat (11) @(negedge clk);
    run0 = 1'b0; run1 = 1'b0;
    #1;
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL abort stall got=%b exp=0", stall0); end
    @(negedge clk);
    #1;
    checks++; if (lo0 !== last_e.lo || hi0 !== last_e.hi) begin failures++; $display("FAIL abort retained lo/hi got=%h/%h exp=%h/%h", lo0, hi0, last_e.lo, last_e.hi); end
    checks++; if (lo1 !== last_e.lo || hi1 !== last_e.hi) begin failures++; $display("FAIL abort fz0 lo/hi got=%h/%h exp=%h/%h", lo1, hi1, last_e.lo, last_e.hi); end
    sb.push_back(model(1'b1, 1'b1, 32'hDEAD_BEEF, 32'd77));
    do_op("after_abort", 1, 1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd77, 0, 33, 33);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    op = 1'b0; sgn = 1'b1; x = 32'd12345; y = 32'd678; ce = 1'b1; run0 = 1'b1; run1 = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0; run0 = 1'b0; run1 = 1'b0;
    #1;
    checks++; if (lo0 !== '0 || hi0 !== '0 || dz0 !== 1'b0) begin failures++; $display("FAIL rst_mid fz1 got lo=%h hi=%h dz=%b exp all 0", lo0, hi0, dz0); end
    checks++; if (lo1 !== '0 || hi1 !== '0 || dz1 !== 1'b0) begin failures++; $display("FAIL rst_mid fz0 got lo=%h hi=%h dz=%b exp all 0", lo1, hi1, dz1); end
    checks++; if (stall0 !== 1'b0 || stall1 !== 1'b0) begin failures++; $display("FAIL rst_mid stall got=%b/%b exp=0", stall0, stall1); end
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(model(1'b0, 1'b1, -32'sd1000, 32'd999));
    do_op("after_rst", 1, 1, 1'b0, 1'b1, -32'sd1000, 32'd999, 0, 33, 33);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; run0 = 1'b0; run1 = 1'b0;
    op = 1'b0; sgn = 1'b0; x = '0; y = '0;
    last_e = '0;
    #12;
    test_reset;
    test_mul;
    test_sdiv;
    test_div_zero;
    test_random;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc5_muldiv.md
RISC5_MULDIV -- requirements
Module: risc5_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal values are 8 to 64, even.
REQ-002 Parameter FAST_ZERO, default 1: when 1, divide-by-zero terminates early.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Port clk  in  1  system clock.
REQ-005 Port rst  in  1  asynchronous reset, active-low.
REQ-006 Port ce  in  1  clock enable; no state changes while ce=0.
REQ-007 Port run  in  1  operation request; held high by the CPU while stall=1.
REQ-008 Port op  in  1  operation select: 0=MUL, 1=DIV.
REQ-009 Port sgn  in  1  operand interpretation: 1=signed two's complement, 0=unsigned.
REQ-010 Port x  in  WIDTH  multiplicand or dividend.
REQ-011 Port y  in  WIDTH  multiplier or divisor.
REQ-012 Port stall  out  1  combinational; high while a result is pending.
REQ-013 Port lo  out  WIDTH  low product half (MUL) or quotient (DIV).
REQ-014 Port hi  out  WIDTH  high product half (MUL) or remainder (DIV).
REQ-015 Port dz  out  1  divide-by-zero flag for the current result.

Function
REQ-016 States: IDLE, BUSY, DONE; transitions occur only on clk edges with ce=1.
REQ-017 IDLE to BUSY when run=1: x, y, op and sgn are captured, and the counter is cleared to 0.
REQ-018 BUSY: one radix-2 step per ce cycle; when the counter reaches WIDTH-1, the state goes to DONE.
REQ-019 DONE to IDLE on the next ce cycle, regardless of run.
REQ-020 stall = run & (state != DONE). With continuous ce, stall is high for exactly WIDTH+1 cycles after run rises.
REQ-021 lo, hi and dz are stable and valid throughout DONE and hold their values in IDLE until the next capture.
REQ-022 If run falls while in BUSY, the operation aborts: the next ce edge goes to IDLE, and lo/hi keep their previous values.
REQ-023 MUL: {hi,lo} = x*y, the full 2*WIDTH-bit product, signed or unsigned per sgn.
REQ-024 Unsigned DIV: lo = floor(x/y), hi = x mod y.
REQ-025 Signed DIV is Euclidean: 0 <= hi < |y|, and x = lo*y + hi.
REQ-026 Signed DIV with x = MIN and y = -1: lo = MIN (wraps), hi = 0, dz = 0.
REQ-027 DIV with y=0: lo = all ones, hi = x, dz = 1.
  - FAST_ZERO=1: BUSY is skipped and the block goes IDLE to DONE directly (stall high for 1 cycle).
  - FAST_ZERO=0: normal latency applies.
REQ-028 dz = 0 for every MUL and for every DIV with y != 0.
REQ-029 Operand changes on x/y/op/sgn during BUSY or DONE are ignored.
REQ-030 A run that is still high in IDLE after DONE starts a new operation; back-to-back operations therefore have a 1-cycle IDLE gap.

Reset
REQ-031 When rst=0, asynchronously: state = IDLE, counter = 0, lo = 0, hi = 0, dz = 0, and internal registers are cleared.
REQ-032 Reset asserted during BUSY discards the operation. After release, stall follows run from IDLE.

Structure
REQ-033 Shared package risc5_muldiv_pkg holds:
  - op encoding constants OP_MUL and OP_DIV;
  - the state enum;
  - counter width = clog2(WIDTH).
REQ-034 Sub-module muldiv_signfix holds:
  - operand absolute-value conversion;
  - result sign/Euclidean correction (purely combinational).
REQ-035 The iterative datapath (shared accumulator/remainder register and shift register) sits in the top module; MUL and DIV share the adder.

Verification (WIDTH=32, continuous ce)
REQ-036 Unsigned MUL 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; stall high 33 cycles.
REQ-037 Signed DIV, three cases:
  - -7/2 -> lo=-4, hi=1;
  - 7/-2 -> lo=-3, hi=1;
  - -7/-2 -> lo=4, hi=1.
REQ-038 DIV 123/0 with FAST_ZERO=1 -> lo=0xFFFFFFFF, hi=123, dz=1, stall high 1 cycle; with FAST_ZERO=0, stall high 33 cycles.
REQ-039 Signed DIV 0x80000000/-1 -> lo=0x80000000, hi=0, dz=0.
REQ-040 Signed MUL -3*5 with ce toggling every other cycle -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall high 33 ce-enabled cycles.
REQ-041 Abort and reset cases:
  - run dropped at BUSY count 10 -> IDLE next edge, previous lo/hi retained;
  - rst pulsed mid-BUSY -> all outputs 0, stall=0 with run=0.
